// File: rtl/shift_serializer.sv
// shift_serializer: parallel word in (ready/valid), RATIO chunks of DATAW bits out, one per enabled cycle.
// Optional build macro SHIFT_SERIALIZER_MSB_FIRST_EN sends the MSB chunk first; default is LSB chunk first.
module shift_serializer #(
    parameter int DATAW = 4,
    parameter int RATIO = 2,
    parameter int CNTW  = (RATIO > 1) ? $clog2(RATIO) : 1
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   in_valid,
    input  logic [DATAW*RATIO-1:0] in_data,
    output logic                   in_ready,
    input  logic                   enable,
    output logic                   out_valid,
    output logic [DATAW-1:0]       out_data,
    output logic                   out_last
);
    localparam int W = DATAW * RATIO;
    localparam logic [CNTW-1:0] LAST = CNTW'(RATIO - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t          state;
    logic [W-1:0]    sreg;
    logic [CNTW-1:0] cnt;
    logic            last, load, adv;

    assign last     = cnt == LAST;
    assign in_ready = resetn && (state == IDLE || (enable && last));
    assign load     = in_valid && in_ready;
    assign adv      = state == SHIFT && enable;

`ifdef SHIFT_SERIALIZER_MSB_FIRST_EN
    assign out_data = sreg[W-1 -: DATAW];
`else
    assign out_data = sreg[DATAW-1:0];
`endif

    // Load, advance or retire the held word; the register is cleared when idle so out_data reads 0.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            cnt       <= '0;
            sreg      <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (load) begin
            state     <= SHIFT;
            cnt       <= '0;
            sreg      <= in_data;
            out_valid <= 1'b1;
            out_last  <= RATIO == 1;
        end else if (adv) begin
            if (last) begin
                state     <= IDLE;
                cnt       <= '0;
                sreg      <= '0;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end else begin
                cnt      <= CNTW'(cnt + 1'b1);
`ifdef SHIFT_SERIALIZER_MSB_FIRST_EN
                sreg     <= sreg << DATAW;
`else
                sreg     <= sreg >> DATAW;
`endif
                out_last <= CNTW'(cnt + 1'b1) == LAST;
            end
        end
    end
endmodule

// File: tb/tb_shift_serializer.sv
// tb_shift_serializer: word-level model check of three serializer shapes plus literal sequence checks.
module tb_shift_serializer;
    localparam int DD [3] = '{4, 8, 4};
    localparam int RR [3] = '{2, 4, 1};

    logic        clk = 1'b0;
    logic        rstn [3];
    logic        vld  [3];
    logic        en   [3];
    logic [31:0] dat  [3];
    logic        ov   [3];
    logic        ol   [3];
    logic        rdy  [3];
    logic [31:0] odw  [3];
    logic [3:0]  od0, od2;
    logic [7:0]  od1;

    logic        busy [3];
    logic [31:0] w    [3];
    int          idx  [3];

    int nv = 0, nf = 0;
    bit go = 1'b0, cap_on = 1'b0;
    logic [5:0]  cap0 [$];
    logic [9:0]  cap1 [$];

    always #5 clk = ~clk;

    shift_serializer #(.DATAW(4), .RATIO(2)) u0 (
        .clk(clk), .resetn(rstn[0]), .in_valid(vld[0]), .in_data(dat[0][7:0]), .in_ready(rdy[0]),
        .enable(en[0]), .out_valid(ov[0]), .out_data(od0), .out_last(ol[0]));
    shift_serializer #(.DATAW(8), .RATIO(4)) u1 (
        .clk(clk), .resetn(rstn[1]), .in_valid(vld[1]), .in_data(dat[1]), .in_ready(rdy[1]),
        .enable(en[1]), .out_valid(ov[1]), .out_data(od1), .out_last(ol[1]));
    shift_serializer #(.DATAW(4), .RATIO(1)) u2 (
        .clk(clk), .resetn(rstn[2]), .in_valid(vld[2]), .in_data(dat[2][3:0]), .in_ready(rdy[2]),
        .enable(en[2]), .out_valid(ov[2]), .out_data(od2), .out_last(ol[2]));

    assign odw[0] = 32'(od0);
    assign odw[1] = 32'(od1);
    assign odw[2] = 32'(od2);

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        nv++;
        if (a !== e) begin
            nf++;
            $display("FAIL %s: got %h want %h", n, a, e);
        end
    endtask

    function automatic logic mrdy(input int i);
        return rstn[i] && (!busy[i] || (en[i] && idx[i] == RR[i] - 1));
    endfunction

    // Which chunk of the held word is on the wire for a given position in the word.
    function automatic logic [31:0] chunk(input int i);
        int k;
`ifdef SHIFT_SERIALIZER_MSB_FIRST_EN
        k = RR[i] - 1 - idx[i];
`else
        k = idx[i];
`endif
        return (w[i] >> (k * DD[i])) & ((32'h1 << DD[i]) - 1);
    endfunction

    // Word-level model: a held word and which of its chunks is on the wire.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rstn[i]) begin
                busy[i] <= 1'b0;
                idx[i]  <= 0;
            end else if (vld[i] && mrdy(i)) begin
                busy[i] <= 1'b1;
                w[i]    <= dat[i] & ((DD[i] * RR[i] >= 32) ? 32'hFFFF_FFFF : ((32'h1 << (DD[i] * RR[i])) - 1));
                idx[i]  <= 0;
            end else if (busy[i] && en[i]) begin
                if (idx[i] == RR[i] - 1) busy[i] <= 1'b0;
                else idx[i] <= idx[i] + 1;
            end
        end
    end

    // Compare every output of every instance against the model, and capture sequences.
    always @(negedge clk) begin
        if (go) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("u%0d.out_valid", i), 32'(ov[i]), 32'(busy[i]));
                chk($sformatf("u%0d.out_data", i), odw[i], busy[i] ? chunk(i) : 32'h0);
                chk($sformatf("u%0d.out_last", i), 32'(ol[i]), 32'(busy[i] && idx[i] == RR[i] - 1));
                chk($sformatf("u%0d.in_ready", i), 32'(rdy[i]), 32'(mrdy(i)));
            end
            if (cap_on && ov[0]) cap0.push_back({rdy[0], ol[0], od0});
            if (cap_on && ov[1]) cap1.push_back({rdy[1], ol[1], od1});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        for (int i = 0; i < 3; i++) begin
            rstn[i] = 1'b1; vld[i] = 1'b0; en[i] = 1'b1; dat[i] = '0;
        end
    endtask

    task automatic seq0(input string n, input logic [5:0] e [$]);
        chk({n, "_len"}, 32'(cap0.size()), 32'(e.size()));
        for (int k = 0; k < e.size(); k++)
            chk($sformatf("%s_%0d", n, k), k < cap0.size() ? 32'(cap0[k]) : 32'hDEAD, 32'(e[k]));
        cap0.delete();
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rstn[i] = 1'b0; vld[i] = 1'b0; en[i] = 1'b0; dat[i] = '0;
        end
        tick();
        go = 1'b1;
        chk("reset_valid", 32'(ov[0]), 32'h0);
        chk("reset_data", odw[0], 32'h0);
        chk("reset_ready", 32'(rdy[0]), 32'h0);
        tick();
        idle_all();
        tick();
        cap_on = 1'b1;

        vld[0] = 1'b1; dat[0] = 32'hA5; tick();
        vld[0] = 1'b0; tick(); tick(); tick();
`ifdef SHIFT_SERIALIZER_MSB_FIRST_EN
        seq0("t1_msb", '{6'h0A, 6'h35});
`else
        seq0("t1", '{6'h05, 6'h3A});
`endif

        vld[0] = 1'b1; dat[0] = 32'h12; tick();
        dat[0] = 32'h34; tick(); tick();
        vld[0] = 1'b0; tick(); tick(); tick();
`ifndef SHIFT_SERIALIZER_MSB_FIRST_EN
        seq0("t2", '{6'h02, 6'h31, 6'h04, 6'h33});
`endif
        cap0.delete();

        vld[0] = 1'b1; dat[0] = 32'hA5; tick();
        vld[0] = 1'b0; tick();
        en[0] = 1'b0; tick(); tick();
        en[0] = 1'b1; tick(); tick();
`ifndef SHIFT_SERIALIZER_MSB_FIRST_EN
        seq0("t3", '{6'h05, 6'h1A, 6'h1A, 6'h3A});
`endif
        cap0.delete();

        vld[0] = 1'b1; dat[0] = 32'hA5; tick();
        vld[0] = 1'b0; rstn[0] = 1'b0; tick();
        rstn[0] = 1'b1;
        chk("t4_after_reset_valid", 32'(ov[0]), 32'h0);
        chk("t4_after_reset_data", odw[0], 32'h0);
        tick();
        vld[0] = 1'b1; dat[0] = 32'h3C; tick();
        vld[0] = 1'b0; tick(); tick(); tick();
`ifndef SHIFT_SERIALIZER_MSB_FIRST_EN
        seq0("t4", '{6'h05, 6'h0C, 6'h33});
`endif
        cap0.delete();

        vld[1] = 1'b1; dat[1] = 32'hDEADBEEF; tick();
        vld[1] = 1'b0; for (int k = 0; k < 5; k++) tick();
        chk("t5_len", 32'(cap1.size()), 32'd4);
`ifdef SHIFT_SERIALIZER_MSB_FIRST_EN
        chk("t5_0", 32'(cap1[0]), 32'h0DE); chk("t5_1", 32'(cap1[1]), 32'h0AD);
        chk("t5_2", 32'(cap1[2]), 32'h0BE); chk("t5_3", 32'(cap1[3]), 32'h3EF);
`else
        chk("t5_0", 32'(cap1[0]), 32'h0EF); chk("t5_1", 32'(cap1[1]), 32'h0BE);
        chk("t5_2", 32'(cap1[2]), 32'h0AD); chk("t5_3", 32'(cap1[3]), 32'h3DE);
`endif
        cap_on = 1'b0;

        vld[2] = 1'b1; dat[2] = 32'h7; en[2] = 1'b0; tick();
        vld[2] = 1'b0;
        chk("r1_last", 32'(ol[2]), 32'h1);
        chk("r1_data", odw[2], 32'h7);
        tick();
        chk("r1_hold", odw[2], 32'h7);
        en[2] = 1'b1; tick();

        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 3; i++) begin
                rstn[i] = $urandom_range(0, 39) != 0;
                en[i]   = $urandom_range(0, 9) < 7;
                vld[i]  = $urandom_range(0, 9) < 6;
                dat[i]  = $urandom;
            end
            tick();
        end
        idle_all();
        tick(); tick(); tick(); tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", nv, nf);
        $finish;
    end
endmodule

// File: doc/shift_serializer.md
# shift_serializer

Parallel-to-serial shift register with a ready/valid load port and an enable-gated output. It accepts a wide word, for example a GMII byte, and shifts it out as RATIO chunks of DATAW bits, for example MII nibbles, one chunk per enabled cycle. It is the transmit-side counterpart of the core's serial-in delay and deserialize shift registers, and it sits between the TX MAC datapath and the narrow PHY-side interface.

## Interface
- DATAW, 4, width of one output chunk in bits (≥1)
- RATIO, 2, number of chunks per input word (≥1)
- CNTW, $clog2(RATIO) (min 1), width of the chunk counter

- clk  input  1  rising-edge clock
- resetn  input  1  synchronous, active-low reset
- in_valid  input  1  in_data holds a word to load
- in_data  input  DATAW*RATIO  parallel word; chunk k = bits [k*DATAW +: DATAW]
- in_ready  output  1  block can take in_data this cycle (combinational)
- enable  input  1  output advance strobe (PHY clock enable)
- out_valid  output  1  out_data holds a live chunk
- out_data  output  DATAW  current chunk
- out_last  output  1  current chunk is the final chunk of its word

## Operation
- Two states: IDLE and SHIFT.
  - IDLE: out_valid=0, out_data=0, out_last=0.
  - SHIFT: a word is held and its chunk count is in `cnt`.
- Load occurs on in_valid && in_ready.
  - The word is captured into the shift register and `cnt` is set to 0.
  - The state goes to SHIFT.
- In SHIFT with enable=1, the current chunk is consumed.
  - If cnt<RATIO-1: the register shifts by DATAW toward chunk 0, and cnt increments.
  - If cnt==RATIO-1: the word is done. A simultaneous load goes to SHIFT with the new word; otherwise the state goes to IDLE.
- In SHIFT with enable=0: out_data, out_last and cnt hold.
- in_ready = resetn && (state==IDLE || (enable && cnt==RATIO-1)). This allows back-to-back words without a bubble.
- Ordering: out_data is always chunk 0 of the shifted register, so the LSB chunk goes first. Ethernet nibble order is low nibble first.
- out_last = out_valid && cnt==RATIO-1.
- RATIO=1: the block acts as a single registered stage.
  - out_last is 1 whenever out_valid=1.
  - in_ready = idle || enable.
- A word offered while busy and not on its last enabled chunk is not accepted; in_ready=0. The upstream holds in_data.

## Timing
- Reset (resetn=0 at a clk edge): state=IDLE, cnt=0, register cleared. out_valid=0, out_data=0, out_last=0.
- in_ready is forced to 0 while resetn=0.
- Reset mid-word discards the word. No partial output follows reset.
- Latency: a word loaded at edge N presents chunk 0 in the cycle after edge N.
- Each subsequent enabled edge advances one chunk.
- Throughput: with enable held high, there is one chunk per cycle and words are contiguous.
- A word occupies exactly RATIO enabled cycles.
- enable is ignored in IDLE; it has no effect on the counter or the data.
- A simultaneous last-chunk consume and new load behaves as follows:
  - The new word's chunk 0 appears the next cycle.
  - out_valid stays 1.
  - out_last drops to 0 (RATIO>1).

## Configuration
- SHIFT_SERIALIZER_MSB_FIRST_EN defined:
  - chunk order is reversed; the MSB chunk (bits [DATAW*RATIO-1 -: DATAW]) goes out first.
  - the register shifts toward the top.
  - out_last still marks the final (LSB) chunk.
- Not defined: LSB-first order, as described above.

## Test plan
- DATAW=4, RATIO=2, enable=1, load 0xA5 → out_data 0x5 (out_last=0), then 0xA (out_last=1), then out_valid=0 and out_data=0.
- Back-to-back 0x12 and 0x34 with enable=1 and in_valid held → out_data 2,1,4,3 with no gap. in_ready=1 on the cycles showing 0x1 and 0x3.
- Load 0xA5 with enable pattern 1,0,0,1 → 0x5 for one cycle, then 0xA held for three cycles, with out_last=1 throughout. in_ready=0 on the enable=0 cycles.
- Load 0xA5, then drive resetn=0 for one cycle while 0x5 is showing → out_valid=0, out_data=0, in_ready=0 that cycle. 0xA never appears, and the next load of 0x3C yields C,3.
- DATAW=8, RATIO=4, enable=1, load 0xDEADBEEF → EF, BE, AD, DE, with out_last only on DE.
- With SHIFT_SERIALIZER_MSB_FIRST_EN, DATAW=4, RATIO=2, load 0xA5 → 0xA then 0x5, with out_last on 0x5.
